// File: rtl/dds_wavegen_mc_if.sv
// Shadow-register configuration bus for dds_wavegen_mc.
// One write port plus per-channel commit strobes.
interface dds_wavegen_mc_if #(
  parameter int CH_NUM = 2,
  parameter int CH_W   = 1
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [2:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [CH_NUM-1:0] cfg_commit;

  modport master (
    output cfg_we, cfg_ch, cfg_addr,
    output cfg_wdata, cfg_commit
  );
  modport slave (
    input cfg_we, cfg_ch, cfg_addr,
    input cfg_wdata, cfg_commit
  );
endinterface

// File: rtl/dds_wavegen_mc.sv
// Multi-channel DDS: phase accumulators, waveform shaping,
// amplitude scaling and per-channel linear frequency sweep.
module dds_wavegen_mc #(
  parameter int CH_NUM  = 2,
  parameter int CH_W    = 1,
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 10,
  parameter int AMP_W   = 8,
  parameter int OUT_W   = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync_rst,
  dds_wavegen_mc_if.slave         cfg,
  output logic [CH_NUM*OUT_W-1:0] wav_out,
  output logic                    wav_valid,
  output logic [CH_NUM-1:0]       wrap,
  output logic [CH_NUM-1:0]       sweep_busy
);
  localparam int PW = DATA_W + AMP_W;
  localparam logic [DATA_W-1:0] HALF =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MID =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [1:0]         ctrl;
    logic [PHASE_W-1:0] fin;
    logic [PHASE_W-1:0] step;
    logic [AMP_W-1:0]   amp;
    logic [DATA_W-1:0]  duty;
    logic [1:0]         sel;
    logic [PHASE_W-1:0] ofs;
    logic [PHASE_W-1:0] freq;
  } regs_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_t;

  logic [2:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= {vld_q[1:0], en};
  end

  assign wav_valid = vld_q[2];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    regs_t              sh_q;
    regs_t              sh_d;
    regs_t              act_q;
    sweep_t             st_q;
    sweep_t             st_d;
    logic [PHASE_W-1:0] inc_q;
    logic [PHASE_W-1:0] inc_d;
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] ph;
    logic [PHASE_W:0]   add;
    logic [PHASE_W:0]   sum;
    logic [DATA_W-1:0]  p_q;
    logic [DATA_W-1:0]  s_q;
    logic [DATA_W-1:0]  s_d;
    logic [DATA_W-1:0]  tp;
    logic [DATA_W-1:0]  tri_v;
    logic [PW-1:0]      prod;
    logic [OUT_W-1:0]   out_q;
    logic               hit;
    logic               commit;
    logic               wrap_q;
    logic               unused_bits;

    assign hit    = cfg.cfg_we && (cfg.cfg_ch == CH_W'(k));
    assign commit = cfg.cfg_commit[k];

    // A same-cycle write is folded in before the commit copy.
    always_comb begin
      sh_d = sh_q;
      if (hit) begin
        case (cfg.cfg_addr)
          3'd0:    sh_d.freq = cfg.cfg_wdata[PHASE_W-1:0];
          3'd1:    sh_d.ofs  = cfg.cfg_wdata[PHASE_W-1:0];
          3'd2:    sh_d.sel  = cfg.cfg_wdata[1:0];
          3'd3:    sh_d.duty = cfg.cfg_wdata[DATA_W-1:0];
          3'd4:    sh_d.amp  = cfg.cfg_wdata[AMP_W-1:0];
          3'd5:    sh_d.step = cfg.cfg_wdata[PHASE_W-1:0];
          3'd6:    sh_d.fin  = cfg.cfg_wdata[PHASE_W-1:0];
          default: sh_d.ctrl = cfg.cfg_wdata[1:0];
        endcase
      end
    end

    assign add = {1'b0, acc_q} + {1'b0, inc_q};
    assign sum = {1'b0, inc_q} + {1'b0, act_q.step};

    always_comb begin
      st_d  = st_q;
      inc_d = inc_q;
      if (commit) begin
        inc_d = sh_d.freq;
        st_d  = sh_d.ctrl[0] ? RUN : IDLE;
      end else if (st_q == RUN && wrap_q) begin
        if (sum >= {1'b0, act_q.fin}) begin
          inc_d = act_q.ctrl[1] ? act_q.freq : act_q.fin;
          st_d  = act_q.ctrl[1] ? RUN : DONE;
        end else begin
          inc_d = sum[PHASE_W-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_q   <= '0;
        act_q  <= '0;
        st_q   <= IDLE;
        inc_q  <= '0;
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        sh_q  <= sh_d;
        st_q  <= st_d;
        inc_q <= inc_d;
        if (commit) act_q <= sh_d;
        if (sync_rst)  acc_q <= '0;
        else if (en)   acc_q <= add[PHASE_W-1:0];
        wrap_q <= en && !sync_rst && add[PHASE_W];
      end
    end

    assign ph    = acc_q + act_q.ofs;
    assign tp    = {p_q[DATA_W-2:0], 1'b0};
    assign tri_v = p_q[DATA_W-1] ? ~tp : tp;

    always_comb begin
      s_d = '0;
      unique case (act_q.sel)
        2'd0:    s_d = p_q - HALF;
        2'd1:    s_d = tri_v - HALF;
        2'd2:    s_d = (p_q < act_q.duty) ? ~HALF : HALF;
        default: s_d = act_q.duty;
      endcase
    end

    // Sign-extended sample times zero-extended gain, mod 2^PW.
    assign prod = {{AMP_W{s_q[DATA_W-1]}}, s_q}
                * {{DATA_W{1'b0}}, act_q.amp};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q   <= '0;
        s_q   <= '0;
        out_q <= MID;
      end else begin
        p_q   <= ph[PHASE_W-1 -: DATA_W];
        s_q   <= s_d;
        out_q <= prod[PW-1 -: OUT_W] ^ MID;
      end
    end

    assign unused_bits = ^{cfg.cfg_wdata, ph, prod};

    assign wav_out[k*OUT_W +: OUT_W] = out_q;
    assign wrap[k]                   = wrap_q;
    assign sweep_busy[k]             = (st_q == RUN);
  end
endmodule

// File: tb/tb_dds_wavegen_mc.sv
// Bench for dds_wavegen_mc: vector table, corner sequences
// and random traffic against an arithmetic reference model.
module tb_dds_wavegen_mc;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int OW = 14;
  localparam longint MOD = 64'd1 << 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sync_rst = 1'b0;
  logic [NC*OW-1:0] wav_out;
  logic wav_valid;
  logic [NC-1:0] wrap;
  logic [NC-1:0] sweep_busy;
  int checks = 0;
  int errors = 0;

  dds_wavegen_mc_if #(.CH_NUM(NC), .CH_W(CW)) cfg_if ();

  dds_wavegen_mc #(
    .CH_NUM(NC), .CH_W(CW), .PHASE_W(24),
    .DATA_W(10), .AMP_W(8), .OUT_W(OW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sync_rst(sync_rst),
    .cfg(cfg_if.slave),
    .wav_out(wav_out),
    .wav_valid(wav_valid),
    .wrap(wrap),
    .sweep_busy(sweep_busy)
  );

  always #5 clk = ~clk;

  longint sh [NC][8];
  longint act [NC][8];
  longint acc_m [NC];
  longint inc_m [NC];
  int st_m [NC];
  bit wrap_m [NC];
  int p_m [NC];
  int s_m [NC];
  int o_m [NC];
  bit [2:0] v_m;

  function automatic longint fmask(int a);
    case (a)
      0, 1, 5, 6: return MOD - 1;
      2, 7:       return 3;
      3:          return 1023;
      default:    return 255;
    endcase
  endfunction

  function automatic int sample(longint sel, longint duty, int p);
    int t;
    case (sel)
      0: return p - 512;
      1: begin
        t = (p >= 512) ? 1023 - 2 * (p - 512) : 2 * p;
        return t - 512;
      end
      2: return (p < duty) ? 511 : -512;
      default: return (duty >= 512) ? int'(duty) - 1024 : int'(duty);
    endcase
  endfunction

  function automatic int lane(int s, longint amp);
    int prod;
    prod = s * int'(amp);
    return (prod >>> 4) + 8192;
  endfunction

  function automatic logic [OW-1:0] ln(int k);
    return wav_out[k*OW +: OW];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      for (int a = 0; a < 8; a++) begin
        sh[k][a] = 0;
        act[k][a] = 0;
      end
      acc_m[k] = 0; inc_m[k] = 0; st_m[k] = 0;
      wrap_m[k] = 0; p_m[k] = 0; s_m[k] = 0;
      o_m[k] = 8192;
    end
    v_m = '0;
  endtask

  task automatic model_step();
    int o_n [NC];
    int s_n [NC];
    int p_n [NC];
    longint acc_n [NC];
    longint inc_n [NC];
    int st_n [NC];
    bit wrap_n [NC];
    longint sum;
    int c;
    int a;
    for (int k = 0; k < NC; k++) begin
      o_n[k] = lane(s_m[k], act[k][4]);
      s_n[k] = sample(act[k][2], act[k][3], p_m[k]);
      p_n[k] = int'(((acc_m[k] + act[k][1]) % MOD) >> 14);
      sum = acc_m[k] + inc_m[k];
      wrap_n[k] = en && !sync_rst && sum >= MOD;
      acc_n[k] = sync_rst ? 0 : (en ? sum % MOD : acc_m[k]);
      inc_n[k] = inc_m[k];
      st_n[k] = st_m[k];
      if (st_m[k] == 1 && wrap_m[k]) begin
        sum = inc_m[k] + act[k][5];
        if (sum >= act[k][6]) begin
          if ((act[k][7] & 2) != 0) inc_n[k] = act[k][0];
          else begin
            inc_n[k] = act[k][6];
            st_n[k] = 2;
          end
        end else inc_n[k] = sum;
      end
    end
    if (cfg_if.cfg_we && cfg_if.cfg_ch < NC) begin
      c = int'(cfg_if.cfg_ch);
      a = int'(cfg_if.cfg_addr);
      sh[c][a] = longint'(cfg_if.cfg_wdata) & fmask(a);
    end
    for (int k = 0; k < NC; k++) begin
      if (cfg_if.cfg_commit[k]) begin
        for (int r = 0; r < 8; r++) act[k][r] = sh[k][r];
        inc_n[k] = sh[k][0];
        st_n[k] = ((sh[k][7] & 1) != 0) ? 1 : 0;
      end
      o_m[k] = o_n[k]; s_m[k] = s_n[k]; p_m[k] = p_n[k];
      acc_m[k] = acc_n[k]; inc_m[k] = inc_n[k];
      st_m[k] = st_n[k]; wrap_m[k] = wrap_n[k];
    end
    v_m = {v_m[1:0], en};
  endtask

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_check();
    logic [NC*OW-1:0] ev;
    logic [NC-1:0] ew;
    logic [NC-1:0] eb;
    for (int k = 0; k < NC; k++) begin
      ev[k*OW +: OW] = OW'(o_m[k]);
      ew[k] = wrap_m[k];
      eb[k] = (st_m[k] == 1);
    end
    chk("wav_out", 64'(wav_out), 64'(ev));
    chk("wrap", 64'(wrap), 64'(ew));
    chk("wav_valid", 64'(wav_valid), 64'(v_m[2]));
    chk("sweep_busy", 64'(sweep_busy), 64'(eb));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_commit = '0;
    sync_rst = 1'b0;
  endtask

  task automatic wr(int ch, int a, longint d);
    cfg_if.cfg_we = 1'b1;
    cfg_if.cfg_ch = CW'(ch);
    cfg_if.cfg_addr = 3'(a);
    cfg_if.cfg_wdata = 32'(d);
    tick();
  endtask

  task automatic cm(logic [NC-1:0] m, logic s);
    cfg_if.cfg_commit = m;
    sync_rst = s;
    tick();
  endtask

  typedef struct {
    int sel;
    int duty;
    int amp;
    int p;
    int exp;
  } vec_t;

  vec_t vt [14];
  int n;
  int nw;
  bit drop;

  initial begin
    vt[0]  = '{0, 0,     255, 0,    'h0020};
    vt[1]  = '{0, 0,     255, 1023, 'h3FD0};
    vt[2]  = '{0, 0,     128, 768,  'h2800};
    vt[3]  = '{0, 0,     0,   100,  'h2000};
    vt[4]  = '{1, 0,     255, 0,    'h0020};
    vt[5]  = '{1, 0,     255, 511,  'h3FC0};
    vt[6]  = '{1, 0,     255, 512,  'h3FD0};
    vt[7]  = '{2, 256,   255, 0,    'h3FD0};
    vt[8]  = '{2, 256,   255, 256,  'h0020};
    vt[9]  = '{2, 0,     255, 0,    'h0020};
    vt[10] = '{3, 'h1FF, 255, 5,    'h3FD0};
    vt[11] = '{3, 'h200, 128, 5,    'h1000};
    vt[12] = '{3, 'h3FF, 1,   5,    'h1FFF};
    vt[13] = '{3, 1,     1,   5,    'h2000};

    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_wdata = '0;
    cfg_if.cfg_commit = '0;
    model_reset();
    #12;
    chk("rst_wav_out", 64'(wav_out), 64'({NC{14'h2000}}));
    chk("rst_valid", 64'(wav_valid), 64'(0));
    chk("rst_busy", 64'(sweep_busy), 64'(0));
    chk("rst_wrap", 64'(wrap), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      wr(0, 1, longint'(vt[i].p) << 14);
      wr(0, 2, vt[i].sel);
      wr(0, 3, vt[i].duty);
      wr(0, 4, vt[i].amp);
      cm(3'b001, 1'b0);
      repeat (3) tick();
      chk($sformatf("vec%0d", i), 64'(ln(0)), 64'(vt[i].exp));
    end

    en = 1'b1;
    wr(0, 0, 'h4000); wr(0, 1, 0); wr(0, 2, 0); wr(0, 4, 255);
    wr(0, 5, 'h4000); wr(0, 6, 'h10000); wr(0, 7, 1);
    cm(3'b001, 1'b1);
    chk("sweep_start", 64'(sweep_busy[0]), 64'(1));
    nw = 0; n = 0;
    while (sweep_busy[0] && n < 5000) begin
      tick(); n++;
      if (wrap[0]) nw++;
    end
    chk("sweep_wraps", 64'(nw), 64'(3));
    chk("sweep_done", 64'(sweep_busy[0]), 64'(0));
    n = 0;
    while (!wrap[0] && n < 600) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!wrap[0] && n < 600);
    chk("done_period", 64'(n), 64'(256));

    wr(0, 7, 3);
    cm(3'b001, 1'b1);
    nw = 0; n = 0; drop = 0;
    while (nw < 6 && n < 8000) begin
      tick(); n++;
      if (wrap[0]) nw++;
      if (!sweep_busy[0]) drop = 1;
    end
    chk("loop_wraps", 64'(nw), 64'(6));
    chk("loop_busy", 64'(drop), 64'(0));

    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(sweep_busy), 64'(0));
    chk("arst_out", 64'(wav_out), 64'({NC{14'h2000}}));
    chk("arst_valid", 64'(wav_valid), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 2; c++) begin
      wr(c, 0, 'h4000);
      wr(c, 1, (c == 1) ? 'h800000 : 0);
      wr(c, 4, 255);
    end
    cm(3'b011, 1'b1);
    repeat (3) tick();
    chk("ofs_ch0", 64'(ln(0)), 64'('h0020));
    chk("ofs_ch1", 64'(ln(1)), 64'('h2000));
    repeat (600) tick();
    n = 0;
    while (acc_m[0] != MOD - 'h4000 && n < 1100) begin
      tick(); n++;
    end
    chk("sync_wait", 64'(n < 1100), 64'(1));
    sync_rst = 1'b1;
    tick();
    chk("sync_nowrap", 64'(wrap), 64'(0));
    repeat (3) tick();
    chk("sync_phase0", 64'(ln(0)), 64'('h0020));

    cfg_if.cfg_we = 1'b1;
    cfg_if.cfg_ch = 2'd0;
    cfg_if.cfg_addr = 3'd4;
    cfg_if.cfg_wdata = 32'd0;
    cfg_if.cfg_commit = 3'b001;
    tick();
    repeat (3) tick();
    chk("we_commit_mid", 64'(ln(0)), 64'('h2000));

    wr(3, 4, 0);
    wr(3, 2, 3);
    cm(3'b111, 1'b0);
    repeat (4) tick();

    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) begin
        cfg_if.cfg_we = 1'b1;
        cfg_if.cfg_ch = CW'($urandom_range(0, 3));
        cfg_if.cfg_addr = 3'($urandom_range(0, 7));
        cfg_if.cfg_wdata = $urandom;
      end
      if ($urandom_range(0, 19) == 0)
        cfg_if.cfg_commit = NC'($urandom_range(0, 7));
      sync_rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
